spi_slave_machine: RTL and testbench
====================================

Name: spi_slave_machine

Overview:
- SPI target-side frame engine: the responder to the controller-side SPI machine.
- Oversamples SCLK/CS_N/MOSI in the `clk` domain, deserialises MOSI words of programmable length, and serialises MISO words from a single-entry transmit holding buffer.
- Reports busy, word-complete, frame-complete and word-count status in the same format as the controller's status register.
- Sits between the chip pads and the peripheral register/FIFO logic.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on spi_sclk/spi_cs_n/spi_mosi (2..3).

Ports:
- clk  in  1  system clock; must be at least 4x SCLK frequency
- rst_n  in  1  synchronous active-low reset
- wlen  in  5  word length minus one (word = wlen+1 bits, 1..32)
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- spi_sclk  in  1  serial clock from controller (asynchronous)
- spi_cs_n  in  1  chip select, active low (asynchronous)
- spi_mosi  in  1  serial data in (asynchronous)
- spi_miso  out  1  serial data out
- spi_miso_oe  out  1  MISO pad output enable
- tx_data  in  32  next word to transmit, right-justified, MSB = bit wlen
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding buffer empty
- rx_data  out  32  received word, right-justified, bits above wlen are zero
- rx_valid  out  1  one-cycle pulse when rx_data is updated
- busy  out  1  frame in progress
- wc  out  1  word complete, sticky
- fc  out  1  frame complete, sticky
- wdcnt  out  12  words completed in the current/last frame
- underrun  out  1  a word started with an empty tx buffer, sticky

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE; shift registers and holding buffer cleared.
  - Outputs: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, wc=0, fc=0, wdcnt=0, underrun=0.
  - A reset mid-frame aborts silently (no fc).
- Input sampling and edge detection:
  - Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
  - Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- tx handshake:
  - Transfer occurs when tx_valid && tx_ready; the buffer becomes full and tx_ready=0 on the next cycle.
  - A load into the shift register empties the buffer; tx_ready returns to 1 the cycle after.
  - Accept and consume can never coincide.
- States:
  - ARMED_WAIT: entered from reset if synced cs_n is low. Goes to IDLE once cs_n is seen high, so the block never joins a frame in progress.
  - IDLE: spi_miso_oe=0, busy=0. On synced cs_n falling → LOAD.
  - LOAD (1 cycle): busy=1, wc=0, fc=0, wdcnt=0, bit_cnt=wlen. txsr loads from the buffer, or from the fill word if the buffer is empty. spi_miso_oe=1 from this cycle. skip=cpha. → SHIFT.
  - SHIFT:
    - Sample edge: rxsr = {rxsr[30:0], mosi}. If bit_cnt≠0, decrement bit_cnt; else → WORD.
    - Shift edge: if skip, clear skip; else txsr shifts left by 1.
    - spi_miso = txsr[wlen] at all times in SHIFT.
  - WORD (1 cycle):
    - rx_data = rxsr masked to wlen+1 bits; rx_valid=1.
    - wc=1; wdcnt+1 (wraps at 4096); bit_cnt=wlen.
    - txsr reloads from buffer/fill; skip=1.
    - → SHIFT.
  - Synced cs_n rising in LOAD/SHIFT/WORD → IDLE:
    - fc=1, busy=0, spi_miso_oe=0.
    - A partial word is discarded: no rx_valid, wc unchanged.
    - If in WORD that cycle, the word's updates complete first.
- cs_n rising and a sample edge in the same cycle: cs_n wins; the edge is ignored.
- wlen/cpol/cpha must be static while busy; changes take effect at the next LOAD.
- No rx backpressure: consumer must take rx_data within one word time; it is overwritten otherwise.

Optional Feature:
- SPI_SLV_UNDERRUN_EN defined:
  - An empty buffer at LOAD/WORD sets underrun (cleared only by reset).
  - Fill word is all-ones.
- Not defined: underrun tied to 0; fill word is all-zeros.

Test Plan:
- cpol=0, cpha=0, wlen=7, tx_data=0xA5 preloaded; controller sends 0x3C → rx_data=0x3C with one rx_valid; MISO bits 1,0,1,0,0,1,0,1; wc=1, wdcnt=1, fc=1 after cs_n high.
- cpol=1, cpha=1, wlen=15, three words 0x1234/0xBEEF/0x0001 each way, buffer refilled after each tx_ready → three rx_valid pulses with matching data; wdcnt=3; MISO matches with no dropped first bit on words 2 and 3.
- wlen=31, tx not loaded, 32 bits sent → MISO all-ones and underrun=1 (macro on); all-zeros and underrun=0 (macro off).
- cs_n deasserted after 5 of 8 bits → no rx_valid, wc=0, fc=1, busy=0, spi_miso_oe=0 within SYNC_STAGES+2 cycles.
- rst_n asserted with cs_n low mid-frame, then released → outputs at reset values; no LOAD until cs_n seen high then low; next frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_slave_machine.sv
// rtl/spi_slave_machine.sv - SPI target frame engine; optional underrun/fill behaviour via SPI_SLV_UNDERRUN_EN
module spi_slave_machine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  wlen,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        wc,
    output logic        fc,
    output logic [11:0] wdcnt,
    output logic        underrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_WORD  = 3'd4;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;

    logic [2:0]  r_state;
    logic [31:0] r_txsr;
    logic [31:0] r_rxsr;
    logic [4:0]  r_bit_cnt;
    logic        r_skip;
    logic [31:0] r_hold;
    logic        r_hold_full;
    logic [31:0] r_rx_data;
    logic        r_rx_valid;
    logic        r_wc;
    logic        r_fc;
    logic [11:0] r_wdcnt;

    logic        w_sclk;
    logic        w_cs;
    logic        w_mosi;
    logic        w_lead;
    logic        w_trail;
    logic        w_sample;
    logic        w_shift;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_busy;
    logic        w_load;
    logic [31:0] w_mask;
    logic [31:0] w_fill;
    logic [31:0] w_tx_word;

    // Synchronisers held at zero in reset, so a low cs_n must be seen high before any frame is joined
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead    = (w_sclk != cpol) && (r_sclk_hist == cpol);
    assign w_trail   = (w_sclk == cpol) && (r_sclk_hist != cpol);
    assign w_sample  = cpha ? w_trail : w_lead;
    assign w_shift   = cpha ? w_lead : w_trail;
    assign w_cs_fall = !w_cs && r_cs_hist;
    assign w_cs_rise = w_cs && !r_cs_hist;
    assign w_mask    = 32'hFFFF_FFFF >> (5'd31 - wlen);
    assign w_busy    = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_WORD);
    // A word boundary that coincides with cs_n rising does not pull from the buffer
    assign w_load    = (r_state == S_LOAD && !w_cs_rise) || (r_state == S_WORD && !w_cs_rise);
`ifdef SPI_SLV_UNDERRUN_EN
    assign w_fill    = 32'hFFFF_FFFF;
`else
    assign w_fill    = 32'h0000_0000;
`endif
    assign w_tx_word = r_hold_full ? r_hold : w_fill;

    // Single-entry transmit holding buffer; accept needs empty, consume needs full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

`ifdef SPI_SLV_UNDERRUN_EN
    logic r_underrun;
    // Sticky flag: a word began with nothing queued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_load && !r_hold_full) begin
            r_underrun <= 1'b1;
        end
    end
    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

    // Frame state machine: cs_n rising always wins over a same-cycle SCLK edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_ARMED;
            r_txsr     <= '0;
            r_rxsr     <= '0;
            r_bit_cnt  <= '0;
            r_skip     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_wc       <= 1'b0;
            r_fc       <= 1'b0;
            r_wdcnt    <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_ARMED: begin
                    if (w_cs) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= S_LOAD;
                        r_wc    <= 1'b0;
                        r_fc    <= 1'b0;
                        r_wdcnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        r_fc    <= 1'b1;
                    end else begin
                        r_txsr    <= w_tx_word;
                        r_bit_cnt <= wlen;
                        r_skip    <= cpha;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        r_fc    <= 1'b1;
                    end else if (w_sample) begin
                        r_rxsr <= {r_rxsr[30:0], w_mosi};
                        if (r_bit_cnt != 5'd0) r_bit_cnt <= r_bit_cnt - 5'd1;
                        else                   r_state   <= S_WORD;
                    end else if (w_shift) begin
                        if (r_skip) r_skip <= 1'b0;
                        else        r_txsr <= {r_txsr[30:0], 1'b0};
                    end
                end
                S_WORD: begin
                    r_rx_data  <= r_rxsr & w_mask;
                    r_rx_valid <= 1'b1;
                    r_wc       <= 1'b1;
                    r_wdcnt    <= r_wdcnt + 12'd1;
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        r_fc    <= 1'b1;
                    end else begin
                        r_txsr    <= w_tx_word;
                        r_bit_cnt <= wlen;
                        r_skip    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spi_miso    = w_busy ? r_txsr[wlen] : 1'b0;
    assign spi_miso_oe = w_busy;
    assign busy        = w_busy;
    assign tx_ready    = !r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign wc          = r_wc;
    assign fc          = r_fc;
    assign wdcnt       = r_wdcnt;

endmodule

// File: tb/tb_spi_slave_machine.sv
// tb/tb_spi_slave_machine.sv - scoreboard bench for spi_slave_machine
module tb_spi_slave_machine;

    localparam int H = 6;
`ifdef SPI_SLV_UNDERRUN_EN
    localparam logic [31:0] FILL   = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_UR = 32'd1;
`else
    localparam logic [31:0] FILL   = 32'h0000_0000;
    localparam logic [31:0] EXP_UR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  wlen;
    logic        cpol;
    logic        cpha;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        wc;
    logic        fc;
    logic [11:0] wdcnt;
    logic        underrun;

    int          n_pass = 0;
    int          n_total = 0;
    int          rx_pulses = 0;
    int          base;
    logic [31:0] rx_exp_q[$];
    logic [31:0] miso_exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    spi_slave_machine #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wlen(wlen), .cpol(cpol), .cpha(cpha),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .wc(wc), .fc(fc),
        .wdcnt(wdcnt), .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Received-word monitor: every rx_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_pulses++;
            if (rx_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rx_unexpected: got 0x%08h expected no rx_valid", rx_data);
            end else begin
                mon_exp = rx_exp_q.pop_front();
                check("rx_data", rx_data, mon_exp);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [31:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (tx_ready !== 1'b1) begin
            n_total++;
            $display("FAIL tx_ready_timeout: got 0 expected 1");
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("tx_ready_after_accept", {31'd0, tx_ready}, 32'd0);
        end
    endtask

    // Controller model; cut >= 0 raises cs_n after that many bits
    task automatic spi_xfer(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input int cut);
        logic [31:0] mo[3];
        logic [31:0] cap;
        logic [31:0] e;
        int nb;
        int sent;
        bit stop;
        mo[0] = w0; mo[1] = w1; mo[2] = w2;
        nb = int'(wlen) + 1;
        sent = 0;
        stop = 1'b0;
        spi_sclk = cpol;
        wait_clks(4);
        spi_cs_n = 1'b0;
        wait_clks(10);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
        for (int w = 0; w < nw && !stop; w++) begin
            cap = '0;
            for (int b = nb - 1; b >= 0 && !stop; b--) begin
                if (cut >= 0 && sent == cut) begin
                    stop = 1'b1;
                end else begin
                    if (!cpha) begin
                        spi_mosi = mo[w][b];
                        wait_clks(H);
                        spi_sclk = ~cpol;
                        cap = {cap[30:0], spi_miso};
                        wait_clks(H);
                        spi_sclk = cpol;
                    end else begin
                        spi_sclk = ~cpol;
                        spi_mosi = mo[w][b];
                        wait_clks(H);
                        spi_sclk = cpol;
                        cap = {cap[30:0], spi_miso};
                        wait_clks(H);
                    end
                    sent++;
                end
            end
            if (!stop) begin
                if (miso_exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL miso_unexpected: got 0x%08h expected none", cap);
                end else begin
                    e = miso_exp_q.pop_front();
                    check("miso_word", cap, e);
                end
            end
        end
        wait_clks(H);
        spi_cs_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wlen = 5'd7; cpol = 1'b0; cpha = 1'b0;
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(1);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wc_fc", {30'd0, wc, fc}, 32'd0);
        check("rst_wdcnt", {20'd0, wdcnt}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        wait_clks(5);

        // Mode 0, one byte each way
        base = rx_pulses;
        push_tx(32'hA5);
        miso_exp_q.push_back(32'hA5);
        rx_exp_q.push_back(32'h3C);
        spi_xfer(1, 32'h3C, 32'h0, 32'h0, -1);
        wait_clks(4);
        check("t1_rx_pulses", rx_pulses - base, 32'd1);
        check("t1_wc", {31'd0, wc}, 32'd1);
        check("t1_wdcnt", {20'd0, wdcnt}, 32'd1);
        check("t1_fc", {31'd0, fc}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Mode 3, three 16-bit words with in-frame refills
        wlen = 5'd15; cpol = 1'b1; cpha = 1'b1;
        base = rx_pulses;
        push_tx(32'h1234);
        miso_exp_q.push_back(32'h1234);
        miso_exp_q.push_back(32'hBEEF);
        miso_exp_q.push_back(32'h0001);
        rx_exp_q.push_back(32'h1234);
        rx_exp_q.push_back(32'hBEEF);
        rx_exp_q.push_back(32'h0001);
        fork
            spi_xfer(3, 32'h1234, 32'hBEEF, 32'h0001, -1);
            begin
                push_tx(32'hBEEF);
                push_tx(32'h0001);
            end
        join
        wait_clks(4);
        check("t2_rx_pulses", rx_pulses - base, 32'd3);
        check("t2_wdcnt", {20'd0, wdcnt}, 32'd3);
        check("t2_wc_fc", {30'd0, wc, fc}, 32'd3);

        // 32-bit word with an empty buffer sends the fill word
        wlen = 5'd31; cpol = 1'b0; cpha = 1'b0;
        check("t3_tx_empty", {31'd0, tx_ready}, 32'd1);
        miso_exp_q.push_back(FILL);
        rx_exp_q.push_back(32'hDEADBEEF);
        spi_xfer(1, 32'hDEADBEEF, 32'h0, 32'h0, -1);
        wait_clks(4);
        check("t3_underrun", {31'd0, underrun}, EXP_UR);
        check("t3_wdcnt", {20'd0, wdcnt}, 32'd1);

        // Abort after 5 of 8 bits
        wlen = 5'd7;
        base = rx_pulses;
        push_tx(32'h81);
        spi_xfer(1, 32'hC3, 32'h0, 32'h0, 5);
        wait_clks(4);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("t4_fc", {31'd0, fc}, 32'd1);
        check("t4_wc", {31'd0, wc}, 32'd0);
        check("t4_rx_pulses", rx_pulses - base, 32'd0);

        // Reset mid-frame with cs_n held low, then a clean frame
        base = rx_pulses;
        push_tx(32'h77);
        spi_sclk = 1'b0;
        wait_clks(4);
        spi_cs_n = 1'b0;
        wait_clks(10);
        for (int b = 0; b < 3; b++) begin
            spi_mosi = b[0];
            wait_clks(H);
            spi_sclk = 1'b1;
            wait_clks(H);
            spi_sclk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("t5_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("t5_flags", {27'd0, wc, fc, underrun, rx_valid, spi_miso}, 32'd0);
        check("t5_wdcnt", {20'd0, wdcnt}, 32'd0);
        check("t5_rx_data", rx_data, 32'd0);
        for (int b = 0; b < 4; b++) begin
            wait_clks(H);
            spi_sclk = 1'b1;
            wait_clks(H);
            spi_sclk = 1'b0;
        end
        check("t5_no_load", {31'd0, busy}, 32'd0);
        spi_cs_n = 1'b1;
        wait_clks(10);
        push_tx(32'h96);
        miso_exp_q.push_back(32'h96);
        rx_exp_q.push_back(32'h5A);
        spi_xfer(1, 32'h5A, 32'h0, 32'h0, -1);
        wait_clks(4);
        check("t5_rx_pulses", rx_pulses - base, 32'd1);
        check("t5_wdcnt_after", {20'd0, wdcnt}, 32'd1);

        check("rx_queue_drained", rx_exp_q.size(), 32'd0);
        check("miso_queue_drained", miso_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
